ncl_sync_tx: RTL and testbench
==============================

# ncl_sync_tx

Clocked-to-NCL transmitter: accepts words from a synchronous valid/ready source, buffers them in a small FIFO, and drives them into an NCL dual-rail pipeline using the standard four-phase DATA/NULL protocol. The NCL stage returns a completion signal `ki`, where 1 requests DATA and 0 requests NULL. The block is the synchronous-side producer for threshold-gate NCL datapaths built from the team's TH-gate cells. It also provides a word counter and a stall watchdog for debug.

## Interface
- WIDTH, 8, data word width (1..32)
- DEPTH, 4, FIFO depth in words (power of 2, ≥2)
- SYNC_STAGES, 2, flops in the `ki` synchronizer (≥2)
- TIMEOUT, 1024, cycles in DATA state before `stall` is flagged (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rsb  in  1  asynchronous active-low reset
- in_data  in  WIDTH  word from the synchronous source
- in_valid  in  1  source has a word
- in_ready  out  1  FIFO can accept; transfer occurs when in_valid & in_ready at a rising edge
- ki  in  1  NCL completion from the receiving stage, asynchronous to clk; 1 = request-for-data, 0 = request-for-null
- out_t  out  WIDTH  dual-rail true rails, registered
- out_f  out  WIDTH  dual-rail false rails, registered
- busy  out  1  FSM in DATA state or FIFO non-empty
- tx_count  out  16  number of completed DATA/NULL cycles, wraps at 65535→0
- stall  out  1  sticky; set when a DATA wavefront is held ≥TIMEOUT cycles

## Operation
- Reset (rsb=0, asynchronous): FSM=IDLE; out_t=out_f=0 (NULL); FIFO empty; in_ready=1; busy=0; tx_count=0; stall=0; synchronizer flops=0; watchdog counter=0.
- `ki` passes through SYNC_STAGES flops to give ki_s. The FSM uses only ki_s.
- FIFO:
  - in_ready = !full, derived from registered pointers.
  - Push when in_valid & in_ready.
  - Pop only on the DATA→IDLE transition.
  - Push and pop in the same cycle are both honoured. When full, in_ready=0, so no push occurs even if a pop happens that cycle.
  - Order is preserved.
- FSM states:
  - IDLE: outputs held NULL. If FIFO non-empty & ki_s=1: register out_t=head, out_f=~head, go to DATA. Otherwise stay in IDLE.
  - DATA: outputs hold the head word. The watchdog increments each cycle and saturates at TIMEOUT; reaching TIMEOUT sets stall. If ki_s=0: register out_t=out_f=0, pop FIFO, tx_count+1, clear watchdog, go to IDLE.
- Protocol invariants:
  - out_t & out_f is all-zero at every cycle; no bit is ever 11.
  - During DATA, every bit pair is exactly one-hot.
  - Outputs change only DATA↔NULL as a whole word. There are no partial transitions, because all rails come from one register.
- Leaving DATA requires ki_s=0. Re-entering DATA requires ki_s=1. This guarantees each NULL is acknowledged before the next DATA.
- stall does not alter protocol behaviour. Only rsb clears it.

## Timing
- Input to FIFO: 1 cycle. A word accepted at edge N is visible as head after edge N.
- Empty FIFO, ki_s already 1: a word pushed at edge N appears on out_t/out_f after edge N+1.
- `ki` rise → DATA driven: ki_s goes high at edge SYNC_STAGES after the rise (first sampling edge counts as 1); outputs update at edge SYNC_STAGES+1.
- `ki` fall → NULL driven: same SYNC_STAGES+1 edges.
- Minimum period of a full DATA+NULL cycle is 2×(SYNC_STAGES+1) clocks plus the NCL stage delay.
- Reset mid-DATA: outputs go NULL immediately and asynchronously. The word in flight is discarded, not retransmitted.
- A `ki` change that is metastable or glitchy is resolved by the synchronizer. A ki pulse shorter than one clock may be missed; the NCL receiver must hold ki until the matching wavefront arrives.

## Test plan
- Reset: assert rsb=0 mid-DATA with out_t=0xA5 → out_t=out_f=0x00 within the same cycle, in_ready=1, tx_count=0, stall=0.
- Single word: ki=1, push 0x3C → after SYNC/FSM latency out_t=0x3C, out_f=0xC3; drop ki → NULL after 3 edges, tx_count=1.
- Back-to-back: push 0x01,0x02,0x03,0x04 while ki toggles via a 5-cycle behavioural TH22 loopback → words emerge in order, every DATA separated by NULL, no 11 rail pair.
- Full FIFO: hold ki=0, push 4 words → in_ready=0 and a 5th push is ignored; release ki → all 4 words delivered and in_ready returns to 1 after the first pop.
- Stall: TIMEOUT=16, hold ki=1 after DATA → stall=1 at the 16th DATA cycle; then drop ki → NULL driven, stall stays 1.
- Wrap: preload 65535 completed cycles (force or long run) → next cycle gives tx_count=0.

Source files
------------

// File: rtl/ncl_sync_tx.sv
// Clocked-to-NCL dual-rail transmitter: a valid/ready FIFO feeds a four-phase
// DATA/NULL handshake paced by a synchronized NCL completion signal (ki).
module ncl_sync_tx #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rsb,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ki,
  output logic [WIDTH-1:0] out_t,
  output logic [WIDTH-1:0] out_f,
  output logic             busy,
  output logic [15:0]      tx_count,
  output logic             stall
);
  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, DATA = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [SYNC_STAGES-1:0] ki_sync_q, ki_sync_d;
  logic [WIDTH-1:0]    out_t_q, out_t_d;
  logic [WIDTH-1:0]    out_f_q, out_f_d;
  logic [15:0]         tx_count_q, tx_count_d;
  logic [WDW-1:0]      wd_q, wd_d;
  logic                stall_q, stall_d;
  logic                ki_s, empty, full, push, load, leave;
  logic [WIDTH-1:0]    head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign ki_s  = ki_sync_q[SYNC_STAGES-1];
  assign push  = in_valid & ~full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rsb) begin
    if (!rsb) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty && ki_s) state_d = DATA;
      DATA:    if (!ki_s)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All rails come from one register, so a wavefront is applied as a whole word.
  always_comb begin
    load       = (state_q == IDLE) && (state_d == DATA);
    leave      = (state_q == DATA) && (state_d == IDLE);
    out_t_d    = out_t_q;
    out_f_d    = out_f_q;
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, leave};
    tx_count_d = tx_count_q + {15'd0, leave};
    ki_sync_d  = {ki_sync_q[SYNC_STAGES-2:0], ki};
    wd_d       = wd_q;
    stall_d    = stall_q;
    if (load) begin
      out_t_d = head;
      out_f_d = ~head;
    end
    if (leave || state_q == IDLE) begin
      if (leave) begin
        out_t_d = '0;
        out_f_d = '0;
      end
      wd_d = '0;
    end else begin
      if (wd_q != WD_MAX) wd_d = wd_q + WDW'(1);
      if (wd_d == WD_MAX) stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rsb) begin
    if (!rsb) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ki_sync_q  <= '0;
      out_t_q    <= '0;
      out_f_q    <= '0;
      tx_count_q <= '0;
      wd_q       <= '0;
      stall_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ki_sync_q  <= ki_sync_d;
      out_t_q    <= out_t_d;
      out_f_q    <= out_f_d;
      tx_count_q <= tx_count_d;
      wd_q       <= wd_d;
      stall_q    <= stall_d;
    end
  end

  assign in_ready = ~full;
  assign busy     = (state_q == DATA) | ~empty;
  assign out_t    = out_t_q;
  assign out_f    = out_f_q;
  assign tx_count = tx_count_q;
  assign stall    = stall_q;

endmodule

// File: tb/tb_ncl_sync_tx.sv
// Bench for ncl_sync_tx: directed scenarios plus random traffic, all checked
// every cycle against a queue-based protocol model.
module tb_ncl_sync_tx;
  localparam int W = 8;
  localparam int D = 4;
  localparam int S = 2;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rsb, in_valid, in_ready, ki, busy, stall;
  logic [W-1:0] in_data, out_t, out_f;
  logic [15:0]  tx_count;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [W-1:0] q_m[$];
  bit           m_data;
  logic [W-1:0] m_t, m_f;
  int           m_cnt, m_wd;
  bit           m_stall;
  bit           ki_seen[$];
  bit           loop_en;
  bit           lb_hist[$];

  always #5 clk = ~clk;

  ncl_sync_tx #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S), .TIMEOUT(T)) dut (
    .clk(clk), .rsb(rsb), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ki(ki), .out_t(out_t), .out_f(out_f),
    .busy(busy), .tx_count(tx_count), .stall(stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    m_data = 0; m_t = '0; m_f = '0; m_cnt = 0; m_wd = 0; m_stall = 0;
    ki_seen.delete();
    repeat (S) ki_seen.push_back(1'b0);
  endtask

  // One rising edge: ki as seen by the FSM is the value sampled S edges ago.
  task automatic model_step();
    bit ks;
    bit do_push;
    ks      = ki_seen[0];
    do_push = in_valid && (q_m.size() < D);
    if (m_data) begin
      if (!ks) begin
        void'(q_m.pop_front());
        m_data = 0; m_t = '0; m_f = '0;
        m_cnt  = (m_cnt + 1) % 65536;
        m_wd   = 0;
      end else begin
        if (m_wd < T) m_wd++;
        if (m_wd == T) m_stall = 1;
      end
    end else if (q_m.size() > 0 && ks) begin
      m_data = 1; m_t = q_m[0]; m_f = ~q_m[0];
    end
    if (do_push) q_m.push_back(in_data);
    void'(ki_seen.pop_front());
    ki_seen.push_back(ki);
  endtask

  task automatic check_all();
    check_eq("out_t", 32'(out_t), 32'(m_t));
    check_eq("out_f", 32'(out_f), 32'(m_f));
    check_eq("in_ready", 32'(in_ready), 32'(q_m.size() < D));
    check_eq("busy", 32'(busy), 32'(m_data || q_m.size() > 0));
    check_eq("tx_count", 32'(tx_count), 32'(m_cnt));
    check_eq("stall", 32'(stall), 32'(m_stall));
    check_eq("no_11", 32'(out_t & out_f), 32'd0);
  endtask

  task automatic lb_start();
    lb_hist.delete();
    repeat (5) lb_hist.push_back(ki);
    loop_en = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (loop_en) begin
      // TH22-style completion: complete DATA requests NULL, NULL requests DATA
      lb_hist.push_back(!((out_t | out_f) == {W{1'b1}}));
      ki = lb_hist.pop_front();
    end
  endtask

  initial begin
    rsb = 1'b0; in_valid = 1'b0; in_data = '0; ki = 1'b0; loop_en = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rsb = 1'b1;

    // Single word
    ki = 1'b1;
    repeat (3) tick();
    in_data = 8'h3C; in_valid = 1'b1; tick(); in_valid = 1'b0;
    tick();
    check_eq("single_t", 32'(out_t), 32'h3C);
    check_eq("single_f", 32'(out_f), 32'hC3);
    ki = 1'b0;
    repeat (2) tick();
    check_eq("single_hold", 32'(out_t), 32'h3C);
    tick();
    check_eq("single_null", 32'(out_t | out_f), 32'd0);
    check_eq("single_cnt", 32'(tx_count), 32'd1);

    // Reset in the middle of a DATA wavefront
    ki = 1'b1;
    in_data = 8'hA5; in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (3) tick();
    check_eq("pre_rst_t", 32'(out_t), 32'hA5);
    rsb = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rsb = 1'b1;

    // Back-to-back through the loopback
    lb_start();
    for (int i = 1; i <= 4; i++) begin
      in_data = W'(i); in_valid = 1'b1; tick();
    end
    in_valid = 1'b0;
    repeat (120) tick();
    check_eq("b2b_cnt", 32'(tx_count), 32'd4);

    // Full FIFO with ki held low
    loop_en = 0; ki = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      in_data = W'(8'h10 + i); in_valid = 1'b1; tick();
      if (i == 3) check_eq("full_rdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    ki = 1'b1;
    lb_start();
    repeat (150) tick();
    check_eq("full_cnt", 32'(tx_count), 32'd8);
    check_eq("full_drain_rdy", 32'(in_ready), 32'd1);

    // Stall watchdog
    loop_en = 0; ki = 1'b1;
    in_data = 8'h5A; in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (10) tick();
    check_eq("stall_pre", 32'(stall), 32'd0);
    repeat (15) tick();
    check_eq("stall_set", 32'(stall), 32'd1);
    ki = 1'b0;
    repeat (4) tick();
    check_eq("stall_null", 32'(out_t | out_f), 32'd0);
    check_eq("stall_sticky", 32'(stall), 32'd1);

    // Random traffic with a free-running ki
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = W'($urandom);
      if ($urandom_range(0, 5) == 0) ki = ~ki;
      tick();
    end
    in_valid = 1'b0;

    // Counter wrap: drain, preload 65535, run one more cycle
    lb_start();
    repeat (100) tick();
    loop_en = 0; ki = 1'b1;
    repeat (2) tick();
    force dut.tx_count_q = 16'hFFFF;
    m_cnt = 65535;
    tick();
    release dut.tx_count_q;
    tick();
    check_eq("wrap_pre", 32'(tx_count), 32'hFFFF);
    in_data = 8'h77; in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (3) tick();
    ki = 1'b0;
    repeat (4) tick();
    check_eq("wrap_cnt", 32'(tx_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
